stream_demux: RTL

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux.sv | 121 ++++++++++++
 1 files changed

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - packet-locked 1-to-2 stream demux with a 2-entry FIFO per output channel
module stream_demux #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              selection_input,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  output logic              out1_last,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out2_data,
  output logic              out2_valid,
  output logic              out2_last,
  input  logic              out2_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT1 = 2'd1,
    PKT2 = 2'd2
  } state_e;

  state_e state_q;

  // Channel index 0 is output channel 1, index 1 is output channel 2.
  logic [DATA_W:0] mem_q [2][2];
  logic [1:0]      cnt_q [2];
  logic [1:0]      cnt_d [2];
  logic [1:0]      wr_ptr_q;
  logic [1:0]      rd_ptr_q;
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      out_ready;
  logic            route_ch1;
  logic            routed_full;
  logic            accept;
  logic [DATA_W:0] head1;
  logic [DATA_W:0] head2;

  assign out_ready = {out2_ready, out1_ready};

  // Pick the destination: live select between packets, locked channel inside one.
  always_comb begin
    route_ch1 = selection_input;
    case (state_q)
      PKT1:    route_ch1 = 1'b1;
      PKT2:    route_ch1 = 1'b0;
      default: route_ch1 = selection_input;
    endcase
  end

  // Readiness depends only on occupancy, so a pop never frees a slot in the same cycle.
  always_comb begin
    routed_full = route_ch1 ? (cnt_q[0] == 2'd2) : (cnt_q[1] == 2'd2);
    in_ready    = rst_n & ~routed_full;
    accept      = in_valid & in_ready;
    push[0]     = accept & route_ch1;
    push[1]     = accept & ~route_ch1;
    for (int c = 0; c < 2; c++) begin
      pop[c]   = (cnt_q[c] != 2'd0) & out_ready[c];
      cnt_d[c] = cnt_q[c] + {1'b0, push[c]} - {1'b0, pop[c]};
    end
  end

  // Packet-lock FSM: a multi-beat packet pins the channel until its last beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (!in_last) state_q <= selection_input ? PKT1 : PKT2;
        end
        PKT1, PKT2: begin
          if (in_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Per-channel FIFO storage, pointers and occupancy; reset discards everything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'b00;
      rd_ptr_q <= 2'b00;
      for (int c = 0; c < 2; c++) begin
        cnt_q[c] <= 2'd0;
        for (int e = 0; e < 2; e++) begin
          mem_q[c][e] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem_q[c][wr_ptr_q[c]] <= {in_last, in_data};
          wr_ptr_q[c]           <= ~wr_ptr_q[c];
        end
        if (pop[c]) begin
          rd_ptr_q[c] <= ~rd_ptr_q[c];
        end
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign head1      = mem_q[0][rd_ptr_q[0]];
  assign head2      = mem_q[1][rd_ptr_q[1]];
  assign out1_valid = (cnt_q[0] != 2'd0);
  assign out2_valid = (cnt_q[1] != 2'd0);
  assign out1_data  = head1[DATA_W-1:0];
  assign out1_last  = head1[DATA_W];
  assign out2_data  = head2[DATA_W-1:0];
  assign out2_last  = head2[DATA_W];

endmodule
